// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S master receiver for the codec ADC; generates mclk/sclk/lrck from clk
// and hands left/right sample pairs downstream through a valid/ack handshake.
module i2s_adc_rx #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sdin,
    output logic              mclk,
    output logic              sclk,
    output logic              lrck,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    input  logic              sample_ack,
    output logic              overrun
);
    localparam logic [4:0] LAST = 5'(DATA_W);

    logic [8:0]        cnt;
    logic              sdin_m, sdin_s;
    logic [DATA_W-1:0] sh, left_hold, word;
    logic [4:0]        bidx;
    logic              sample, data_bit, last_bit, cap_l, cap_r;

    assign mclk     = cnt[0];
    assign sclk     = cnt[2];
    assign lrck     = cnt[8];
    assign bidx     = cnt[7:3];
    // two clk after the sclk rising edge, so sdin_s has settled through the synchronizer
    assign sample   = en && cnt[2:0] == 3'b101;
    assign data_bit = sample && bidx != 5'd0 && bidx <= LAST;
    assign last_bit = sample && bidx == LAST;
    assign cap_l    = last_bit && !cnt[8];
    assign cap_r    = last_bit && cnt[8];
    assign word     = DATA_W'({sh, sdin_s});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            sdin_m       <= 1'b0;
            sdin_s       <= 1'b0;
            sh           <= '0;
            left_hold    <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sdin_m <= sdin;
            sdin_s <= sdin_m;
            cnt    <= en ? cnt + 9'd1 : 9'd0;
            if (!en)
                sh <= '0;
            else if (data_bit)
                sh <= word;
            if (cap_l)
                left_hold <= word;
            if (cap_r) begin
                right_data   <= word;
                left_data    <= left_hold;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ack)
                    overrun <= 1'b1;
            end else if (sample_ack) begin
                sample_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed bench for i2s_adc_rx with an I2S ADC bus model driving sdin
// on sclk falling edges, one bit of delay after each lrck change.
module tb_i2s_adc_rx;
    logic        clk = 1'b0, reset = 1'b1, en = 1'b1, sample_ack = 1'b0;
    logic        sdin_ovr = 1'b0, bfm_bit = 1'b0, prev_lrck = 1'b0;
    logic        sdin, mclk, sclk, lrck, sample_valid, overrun;
    logic [23:0] left_data, right_data, lword = '0, rword = '0;
    int          idx = 0, total = 0, bad = 0, c = 0;

    assign sdin = sdin_ovr | bfm_bit;
    always #5 clk = ~clk;

    i2s_adc_rx #(.DATA_W(24)) dut (
        .clk(clk), .reset(reset), .en(en), .sdin(sdin),
        .mclk(mclk), .sclk(sclk), .lrck(lrck),
        .left_data(left_data), .right_data(right_data),
        .sample_valid(sample_valid), .sample_ack(sample_ack), .overrun(overrun)
    );

    always @(negedge sclk or negedge en or posedge reset) begin
        #1;
        if (!en || reset) begin
            idx = 0;
            prev_lrck = 1'b0;
            bfm_bit = 1'b0;
        end else begin
            idx = (lrck != prev_lrck) ? 0 : idx + 1;
            prev_lrck = lrck;
            bfm_bit = (idx >= 1 && idx <= 24) ? (lrck ? rword[24-idx] : lword[24-idx]) : 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid;
        while (sample_valid !== 1'b1 && c < 700) begin
            step;
            c++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; sdin_ovr = 1'b1;
        lword = 24'hA55A01; rword = 24'h800000;
        repeat (3) step;
        total++;
        if ({mclk, sclk, lrck, sample_valid, overrun} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=00000", {mclk, sclk, lrck, sample_valid, overrun});
        end
        total++;
        if (left_data !== 24'h0 || right_data !== 24'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h exp=0/0", left_data, right_data);
        end
        reset = 1'b0; sdin_ovr = 1'b0; c = 0;
        step; c++;
        total++;
        if (mclk !== 1'b1 || sclk !== 1'b0) begin
            bad++; $display("FAIL first_mclk got mclk=%b sclk=%b exp 1 0", mclk, sclk);
        end
        step; step; c += 2;
        total++;
        if (sclk !== 1'b0) begin
            bad++; $display("FAIL sclk_early got=%b exp=0", sclk);
        end
        step; c++;
        total++;
        if (sclk !== 1'b1) begin
            bad++; $display("FAIL sclk_rise got=%b exp=1", sclk);
        end
    endtask

    task automatic test_known_frame;
        wait_valid;
        total++;
        if (c !== 454) begin
            bad++; $display("FAIL valid_time got=%0d exp=454", c);
        end
        total++;
        if (left_data !== 24'hA55A01 || right_data !== 24'h800000 || overrun !== 1'b0) begin
            bad++; $display("FAIL known_frame got=%h/%h ovr=%b exp=a55a01/800000 ovr=0", left_data, right_data, overrun);
        end
        lword = 24'h000001; rword = 24'hFFFFFF;
    endtask

    task automatic test_overrun;
        while (c < 965) begin step; c++; end
        total++;
        if (right_data !== 24'h800000 || overrun !== 1'b0) begin
            bad++; $display("FAIL pre_overrun got=%h ovr=%b exp=800000 ovr=0", right_data, overrun);
        end
        step; c++;
        total++;
        if (overrun !== 1'b1 || sample_valid !== 1'b1 || left_data !== 24'h000001 || right_data !== 24'hFFFFFF) begin
            bad++; $display("FAIL overrun got ovr=%b v=%b %h/%h exp 1 1 000001/ffffff", overrun, sample_valid, left_data, right_data);
        end
        sample_ack = 1'b1; step; c++; sample_ack = 1'b0;
        total++;
        if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
            bad++; $display("FAIL ack_clear got v=%b ovr=%b exp v=0 ovr=1", sample_valid, overrun);
        end
    endtask

    task automatic test_clocks;
        int mr = 0, sr = 0, lr = 0, lh = 0, viol = 0;
        logic pm, ps, pl;
        for (int i = 0; i < 2048; i++) begin
            pm = mclk; ps = sclk; pl = lrck;
            step; c++;
            if (mclk && !pm) mr++;
            if (sclk && !ps) sr++;
            if (lrck && !pl) lr++;
            if (lrck) lh++;
            if (lrck != pl && sclk) viol++;
        end
        total++;
        if (mr !== 1024 || sr !== 256 || lr !== 4) begin
            bad++; $display("FAIL clk_rates got mclk=%0d sclk=%0d lrck=%0d exp 1024 256 4", mr, sr, lr);
        end
        total++;
        if (lh !== 1024 || viol !== 0) begin
            bad++; $display("FAIL lrck_shape got high=%0d viol=%0d exp 1024 0", lh, viol);
        end
    endtask

    task automatic test_collision;
        reset = 1'b1; sample_ack = 1'b0;
        step;
        lword = 24'h123456; rword = 24'h654321;
        reset = 1'b0; c = 0;
        wait_valid;
        total++;
        if (c !== 454 || left_data !== 24'h123456 || right_data !== 24'h654321) begin
            bad++; $display("FAIL coll_first got c=%0d %h/%h exp 454 123456/654321", c, left_data, right_data);
        end
        lword = 24'h0ABCDE; rword = 24'hFEDCBA;
        while (c < 965) begin step; c++; end
        sample_ack = 1'b1; step; c++; sample_ack = 1'b0;
        total++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0 || left_data !== 24'h0ABCDE || right_data !== 24'hFEDCBA) begin
            bad++; $display("FAIL collision got v=%b ovr=%b %h/%h exp 1 0 0abcde/fedcba", sample_valid, overrun, left_data, right_data);
        end
    endtask

    task automatic test_disable;
        logic seen = 1'b0;
        sample_ack = 1'b1; step; c++; sample_ack = 1'b0;
        total++;
        if (sample_valid !== 1'b0) begin
            bad++; $display("FAIL dis_ack got=%b exp=0", sample_valid);
        end
        while (c < 1107) begin step; c++; end
        en = 1'b0;
        step;
        total++;
        if ({mclk, sclk, lrck} !== 3'b000) begin
            bad++; $display("FAIL dis_clocks got=%b exp=000", {mclk, sclk, lrck});
        end
        repeat (600) begin
            step;
            if (sample_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL dis_capture got seen=%b ovr=%b exp 0 0", seen, overrun);
        end
        lword = 24'h7FFFFF; rword = 24'h000100;
        en = 1'b1; c = 0;
        wait_valid;
        total++;
        if (c !== 454 || left_data !== 24'h7FFFFF || right_data !== 24'h000100) begin
            bad++; $display("FAIL reenable got c=%0d %h/%h exp 454 7fffff/000100", c, left_data, right_data);
        end
    endtask

    task automatic test_reset_mid;
        while (c < 810) begin step; c++; end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({mclk, sclk, lrck, sample_valid, overrun} !== 5'b0 || left_data !== 24'h0 || right_data !== 24'h0) begin
            bad++; $display("FAIL async_reset got ctl=%b %h/%h exp 00000 0/0", {mclk, sclk, lrck, sample_valid, overrun}, left_data, right_data);
        end
        step;
        total++;
        if ({mclk, sclk, lrck, sample_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_hold got=%b exp=0000", {mclk, sclk, lrck, sample_valid});
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_known_frame;
        test_overrun;
        test_clocks;
        test_collision;
        test_disable;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- I2S master receiver for the ADC half of the Digilent I2S codec socket; the receive-direction counterpart of the existing DAC playback path.
- Generates mclk, sclk and lrck from the system clock and shifts serial ADC data in on sdin.
- Delivers left/right sample pairs to downstream logic (recorder, loopback, tone detection) through a valid/ack handshake.
- Clocked by the same divided clock (nominally 25 MHz) as the playback I2S path, so mclk/lrck = 256 and sclk/lrck = 64.

Parameters:
- DATA_W, 24, bits per channel captured; legal range 1..31.

Ports:
- clk  input  1  system clock (nominally 25 MHz divided clock)
- reset  input  1  asynchronous, active-high reset
- en  input  1  capture enable; low stops the I2S clocks and clears the frame position
- sdin  input  1  serial data from the ADC (asynchronous to clk)
- mclk  output  1  ADC master clock, clk/2
- sclk  output  1  bit clock, clk/8
- lrck  output  1  word select, clk/512; 0 = left, 1 = right
- left_data  output  DATA_W  last complete left sample, two's complement
- right_data  output  DATA_W  last complete right sample, two's complement
- sample_valid  output  1  a new sample pair is held
- sample_ack  input  1  consumer accepts the held pair
- overrun  output  1  sticky: a pair was overwritten before it was acknowledged

Behaviour:
- Reset (async, active-high): all outputs 0, frame counter 0, shift register 0, sdin synchronizer 0. Reset asserted mid-frame discards the partial frame immediately.
- Frame counter: 9-bit cnt, increments every clk while en=1.
  - mclk = cnt[0], sclk = cnt[2], lrck = cnt[8].
  - Channel bit index bidx = cnt[7:3], range 0..31.
  - lrck changes only while sclk is low.
- en=0: cnt is held at 0, so mclk, sclk and lrck are low. The shift register clears. The output registers, sample_valid and overrun keep their values and the handshake still operates.
  - Deasserting en mid-frame discards the partial frame; no capture occurs.
  - Re-enabling starts at left channel, bidx 0.
- sdin passes a 2-flop synchronizer (sdin_s).
- Sample point: the cycle with cnt[2:0]==3'b101, two clk after sclk rises and still before it falls.
- Bit framing follows I2S: bidx 0 is the one-bit delay slot and is ignored.
  - bidx 1..DATA_W carry MSB..LSB, shifted into the shift register MSB-first.
  - bidx > DATA_W is ignored.
- Left capture: at the sample point with lrck=0 and bidx==DATA_W, the completed word (including this bit) loads a left hold register. The left_data output does not change yet.
- Right capture: at the sample point with lrck=1 and bidx==DATA_W, on the next clk edge:
  - right_data loads the completed word;
  - left_data loads the left hold register;
  - sample_valid goes to 1.
- Handshake:
  - sample_valid stays high until a clk edge where sample_valid=1 and sample_ack=1; that edge clears it.
  - sample_ack while sample_valid=0 has no effect.
- Simultaneous capture and ack on the same edge: the new pair loads, sample_valid stays 1, overrun is unchanged.
- Capture while sample_valid=1 and sample_ack=0: the new pair overwrites the old one, sample_valid stays 1, overrun is set to 1.
- overrun is cleared only by reset.
- Frame timing: 512 clk per stereo frame. At most one sample_valid rising edge per frame.

Test Plan:
- Reset: hold reset with en=1 and sdin=1 → all outputs 0. Release reset → first mclk rising edge 1 clk later, sclk rising edge 4 clk later.
- Clock generation: en=1 for 2048 clk → mclk period 2, sclk period 8, lrck period 512 with 50% duty. lrck never toggles while sclk=1.
- Known frame: BFM drives left 24'hA55A01 and right 24'h800000 on sclk falling edges with I2S delay → sample_valid rises 1 clk after cnt=={1,5'd24,3'b101}; left_data=24'hA55A01, right_data=24'h800000.
- Handshake: leave the pair unacked while the next frame delivers 24'h000001/24'hFFFFFF → overrun=1, data=24'h000001/24'hFFFFFF. Then pulse sample_ack one cycle → sample_valid=0, overrun remains 1.
- Ack/capture collision: assert sample_ack exactly on the capture edge with a prior pair held → sample_valid stays 1, new data loaded, overrun stays 0.
- Disable and reset mid-frame: drop en at left bidx 10 → mclk, sclk and lrck are 0 next clk and no sample_valid. Re-enable → next valid frame decodes correctly. Assert reset at right bidx 5 → outputs 0 within the same cycle, asynchronously.
